rt_responder: RTL and testbench
===============================

// Module: rt_responder
// PURPOSE
//   Responder side of the request/response handshake driven by the bench environment.
//   Watches the environment request line, and asserts resp (the controllable input of the environment) within a latency deadline.
//   Honours a finite response budget that refills once per window.
//   Flags error when a request is missed; output feeds the model-checking harness as the controller under synthesis.
// PARAMETERS
//   MAX_LAT      3   max cycles from req rise to resp before error (1..15)
//   RESP_BUDGET  3   responses allowed per window (1..15)
//   WINDOW       16  window length in cycles; budget refills on wrap (>= RESP_BUDGET+1)
// PORTS
//   clk          in   1  single clock, all state on rising edge
//   rst          in   1  synchronous, active-high reset
//   req          in   1  environment request (level; held until resp seen)
//   resp         out  1  response pulse, one cycle per served request
//   error        out  1  sticky: request not served within MAX_LAT
//   budget_left  out  4  responses still available in current window
//   pending      out  1  request outstanding, not yet served
// BEHAVIOUR
//   Reset values: resp=0, error=0, pending=0, budget_left=RESP_BUDGET, win_cnt=0, lat_cnt=0, state=IDLE.
//   FSM states: IDLE, WAIT, RESP, STARVED.
//   - IDLE: req=1 & budget_left>0 -> RESP (resp=1 next cycle, latency 1).
//     req=1 & budget_left=0 -> STARVED.
//   - RESP: resp=1 for exactly one cycle, budget_left-=1 in the same cycle.
//     Next state: IDLE if req=0, else WAIT (environment drops req the cycle after resp).
//   - WAIT: req still high after a served resp counts as a new request.
//     Handled like IDLE but lat_cnt keeps running.
//   - STARVED: lat_cnt increments each cycle.
//     Refill while lat_cnt<MAX_LAT -> RESP.
//     lat_cnt==MAX_LAT -> error=1 (sticky until rst), then IDLE.
//     req=0 -> IDLE without error.
//   pending = (state==WAIT | state==STARVED) | (state==IDLE & req).
//   lat_cnt: 4-bit, cleared on entry to RESP or IDLE, saturates at 15.
//   win_cnt: counts 0..WINDOW-1; on wrap, budget_left <= RESP_BUDGET.
//   - Wrap in same cycle as a resp: refill wins, giving RESP_BUDGET, not RESP_BUDGET-1.
//   - budget_left never underflows; resp is never issued with budget_left==0.
//   - req=0 while in RESP: the pulse still completes and budget is still consumed.
//   - rst mid-RESP: resp deasserts the cycle after rst, all counters return to reset values, error clears.
//   - error does not block further responses; it is sticky only.
// STRUCTURE
//   Package rt_pkg: typedef enum logic[1:0] {IDLE,WAIT,RESP,STARVED} rt_state_t; constant widths.
//   Sub-module rt_budget_window: win_cnt + budget_left with refill/consume priority.
//   The FSM and lat_cnt stay in the top.
// TESTING
//   1. rst 2 cycles, req=1 held -> resp=1 on cycle 1 after req; budget_left 3->2; pending falls.
//   2. Four requests in one window (defaults) -> three resp pulses.
//      Fourth enters STARVED; error=1 exactly MAX_LAT=3 cycles later if no wrap.
//   3. Fourth req issued 2 cycles before window wrap -> refill, resp issued, error stays 0, budget_left=2.
//   4. resp on the wrap cycle -> budget_left reads RESP_BUDGET=3 next cycle, not 2.
//   5. req drops during STARVED before deadline -> IDLE, error=0, no resp.
//   6. rst asserted during RESP and during STARVED -> next cycle resp=0, error=0, budget_left=3, state IDLE.

Source files
------------

// File: rtl/rt_pkg.sv
// rtl/rt_pkg.sv - shared types and widths for the request/response responder
package rt_pkg;

  // Width of the latency counter and of the budget count.
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESP    = 2'd2,
    STARVED = 2'd3
  } rt_state_t;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/rt_budget_window.sv
// rtl/rt_budget_window.sv - window counter and per-window response budget
module rt_budget_window
  import rt_pkg::*;
#(
  parameter int RESP_BUDGET = 3,
  parameter int WINDOW      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             consume,
  output logic [CNT_W-1:0] budget_left
);

  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] BUDGET_FULL = CNT_W'(RESP_BUDGET);

  logic [WIN_W-1:0] win_cnt;
  logic             wrap;

  assign wrap = (win_cnt == WIN_LAST);

  // Free-running window counter; the refill lands on the same edge the
  // counter returns to zero, and it overrides a consume on that edge so a
  // response in the last cycle of a window does not eat into the new one.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt     <= '0;
      budget_left <= BUDGET_FULL;
    end else begin
      win_cnt <= wrap ? '0 : win_cnt + WIN_W'(1);
      if (wrap) begin
        budget_left <= BUDGET_FULL;
      end else if (consume && (budget_left != '0)) begin
        budget_left <= budget_left - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/rt_responder.sv
// rtl/rt_responder.sv - responder FSM answering req with budgeted resp pulses
module rt_responder
  import rt_pkg::*;
#(
  parameter int MAX_LAT     = 3,
  parameter int RESP_BUDGET = 3,
  parameter int WINDOW      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  output logic             resp,
  output logic             error,
  output logic [CNT_W-1:0] budget_left,
  output logic             pending
);

  localparam logic [CNT_W-1:0] LAT_LIMIT = CNT_W'(MAX_LAT);

  rt_state_t        state;
  rt_state_t        state_next;
  logic [CNT_W-1:0] lat_cnt;
  logic [CNT_W-1:0] lat_next;
  logic             set_error;
  logic             consume;

  rt_budget_window #(
    .RESP_BUDGET (RESP_BUDGET),
    .WINDOW      (WINDOW)
  ) u_budget (
    .clk         (clk),
    .rst         (rst),
    .consume     (consume),
    .budget_left (budget_left)
  );

  // State, latency counter and sticky error register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lat_cnt <= '0;
      error   <= 1'b0;
    end else begin
      state   <= state_next;
      lat_cnt <= lat_next;
      if (set_error) begin
        error <= 1'b1;
      end
    end
  end

  // Next-state decode; RESP is only entered with budget available, so the
  // pulse that consumes it can never drive the budget below zero.
  always_comb begin
    state_next = state;
    set_error  = 1'b0;
    consume    = 1'b0;
    case (state)
      IDLE, WAIT: begin
        if (!req) begin
          state_next = IDLE;
        end else if (budget_left != '0) begin
          state_next = RESP;
        end else begin
          state_next = STARVED;
        end
      end
      RESP: begin
        consume    = 1'b1;
        state_next = req ? WAIT : IDLE;
      end
      STARVED: begin
        if (!req) begin
          state_next = IDLE;
        end else if (lat_cnt >= LAT_LIMIT) begin
          set_error  = 1'b1;
          state_next = IDLE;
        end else if (budget_left != '0) begin
          state_next = RESP;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Latency restarts whenever the request is served or abandoned and
  // otherwise keeps counting, through WAIT as well as STARVED.
  always_comb begin
    lat_next = sat_inc(lat_cnt);
    if ((state_next == RESP) || (state_next == IDLE)) begin
      lat_next = '0;
    end
  end

  // Moore response pulse and outstanding-request indication.
  always_comb begin
    resp    = (state == RESP);
    pending = (state == WAIT) || (state == STARVED) || ((state == IDLE) && req);
  end

endmodule

// File: tb/tb_rt_responder.sv
// tb/tb_rt_responder.sv - directed self-checking bench for rt_responder
module tb_rt_responder;

  logic       clk;
  logic       rst;
  logic       req;
  logic       resp;
  logic       error;
  logic [3:0] budget_left;
  logic       pending;

  int total;
  int bad;

  rt_responder dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .resp        (resp),
    .error       (error),
    .budget_left (budget_left),
    .pending     (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic expect_outs(input string tag, input logic r, input logic e,
                             input logic [3:0] b, input logic p);
    chk({tag, ".resp"},    32'(resp),        32'(r));
    chk({tag, ".error"},   32'(error),       32'(e));
    chk({tag, ".budget"},  32'(budget_left), 32'(b));
    chk({tag, ".pending"}, 32'(pending),     32'(p));
  endtask

  // Leaves the bench at the falling edge of cycle 0, window count 0.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Advance one cycle, drive inputs just after the rising edge, sample at the falling edge.
  task automatic tick(input logic r, input logic rs);
    @(posedge clk);
    #1;
    req = r;
    rst = rs;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    req   = 1'b0;

    // Reset, first request held into WAIT, budget exhaustion, starvation, error, reset from STARVED.
    do_reset();
    expect_outs("a_reset", 0, 0, 4'd3, 0);
    tick(1, 0); expect_outs("a_c1_req",   0, 0, 4'd3, 1);
    tick(1, 0); expect_outs("a_c2_resp",  1, 0, 4'd3, 0);
    tick(0, 0); expect_outs("a_c3_wait",  0, 0, 4'd2, 1);
    tick(1, 0); expect_outs("a_c4_req",   0, 0, 4'd2, 1);
    tick(0, 0); expect_outs("a_c5_resp",  1, 0, 4'd2, 0);
    tick(1, 0); expect_outs("a_c6_req",   0, 0, 4'd1, 1);
    tick(0, 0); expect_outs("a_c7_resp",  1, 0, 4'd1, 0);
    tick(1, 0); expect_outs("a_c8_empty", 0, 0, 4'd0, 1);
    tick(1, 0); expect_outs("a_c9_stv",   0, 0, 4'd0, 1);
    tick(1, 0); expect_outs("a_c10_stv",  0, 0, 4'd0, 1);
    tick(1, 0); expect_outs("a_c11_stv",  0, 0, 4'd0, 1);
    tick(1, 0); expect_outs("a_c12_err",  0, 1, 4'd0, 1);
    tick(1, 1); expect_outs("a_c13_stv",  0, 1, 4'd0, 1);
    tick(0, 0); expect_outs("a_c14_rst",  0, 0, 4'd3, 0);

    // Reset landing while the response pulse is up.
    do_reset();
    tick(1, 0); expect_outs("e_c1_req",  0, 0, 4'd3, 1);
    tick(1, 1); expect_outs("e_c2_resp", 1, 0, 4'd3, 0);
    tick(1, 0); expect_outs("e_c3_idle", 0, 0, 4'd3, 1);
    tick(0, 0); expect_outs("e_c4_resp", 1, 0, 4'd3, 0);
    tick(0, 0); expect_outs("e_c5_idle", 0, 0, 4'd2, 0);

    // Fourth request two cycles before the wrap is served from the refill.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1, 0); expect_outs($sformatf("b_req%0d", i),  0, 0, 4'(3 - i), 1);
      tick(0, 0); expect_outs($sformatf("b_resp%0d", i), 1, 0, 4'(3 - i), 0);
    end
    for (int c = 7; c < 14; c++) begin
      tick(0, 0); expect_outs($sformatf("b_c%0d_idle", c), 0, 0, 4'd0, 0);
    end
    tick(1, 0); expect_outs("b_c14_req",  0, 0, 4'd0, 1);
    tick(1, 0); expect_outs("b_c15_stv",  0, 0, 4'd0, 1);
    tick(1, 0); expect_outs("b_c16_fill", 0, 0, 4'd3, 1);
    tick(0, 0); expect_outs("b_c17_resp", 1, 0, 4'd3, 0);
    tick(0, 0); expect_outs("b_c18_idle", 0, 0, 4'd2, 0);

    // Response on the last cycle of the window: refill beats consume.
    do_reset();
    tick(1, 0); expect_outs("c_c1_req",  0, 0, 4'd3, 1);
    tick(0, 0); expect_outs("c_c2_resp", 1, 0, 4'd3, 0);
    for (int c = 3; c < 14; c++) begin
      tick(0, 0); expect_outs($sformatf("c_c%0d_idle", c), 0, 0, 4'd2, 0);
    end
    tick(1, 0); expect_outs("c_c14_req",  0, 0, 4'd2, 1);
    tick(0, 0); expect_outs("c_c15_wrap", 1, 0, 4'd2, 0);
    tick(0, 0); expect_outs("c_c16_full", 0, 0, 4'd3, 0);
    tick(1, 0); expect_outs("c_c17_req",  0, 0, 4'd3, 1);
    tick(0, 0); expect_outs("c_c18_resp", 1, 0, 4'd3, 0);
    tick(0, 0); expect_outs("c_c19_idle", 0, 0, 4'd2, 0);

    // Request withdrawn while starved: back to IDLE with no error and no pulse.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1, 0); expect_outs($sformatf("d_req%0d", i),  0, 0, 4'(3 - i), 1);
      tick(0, 0); expect_outs($sformatf("d_resp%0d", i), 1, 0, 4'(3 - i), 0);
    end
    tick(1, 0); expect_outs("d_c7_req",  0, 0, 4'd0, 1);
    tick(1, 0); expect_outs("d_c8_stv",  0, 0, 4'd0, 1);
    tick(0, 0); expect_outs("d_c9_drop", 0, 0, 4'd0, 1);
    for (int c = 10; c < 16; c++) begin
      tick(0, 0); expect_outs($sformatf("d_c%0d_idle", c), 0, 0, 4'd0, 0);
    end
    tick(0, 0); expect_outs("d_c16_fill", 0, 0, 4'd3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
